// File: rtl/cameralink_pkg.sv
// Shared types for the Camera Link capture path: sequencer state encoding
// and the tuser bit that flags start-of-frame.
package cameralink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } capture_state_t;

  localparam int SOF_BIT = 0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice: an output register plus one skid slot.
// Fullness is exported one cycle early so the upstream ready can be a flop.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_next_o,
  output logic             empty_next_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             pop;

  assign pop = out_valid_q & m_ready_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = push_i;
        skid_data_d  = data_i;
      end else begin
        out_valid_d = push_i;
        if (push_i) out_data_d = data_i;
      end
    end else if (push_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid_q, so it carries no reset and stays a plain data register.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign full_next_o  = skid_valid_d;
  assign empty_next_o = ~out_valid_d;
  assign m_valid_o    = out_valid_q;
  assign m_data_o     = out_data_q;

endmodule

// File: rtl/cameralink_capture_ctrl.sv
// Capture sequencer gating the Camera Link AXI4-Stream into a frame-counted run.
// Define CAMLINK_CAPTURE_STATS_EN to enable the line-width / frame-height statistics.
module cameralink_capture_ctrl
  import cameralink_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_USER_WIDTH = 1,
  parameter int FRAME_CNT_W     = 16,
  parameter int DIM_W           = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]   s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                         cfg_start,
  input  logic                         cfg_stop,
  input  logic [FRAME_CNT_W-1:0]       cfg_num_frames,
  input  logic [DIM_W-1:0]             cfg_height,
  output logic                         sts_busy,
  output logic                         sts_done,
  output logic [FRAME_CNT_W-1:0]       sts_frames,
  output logic                         sts_err_short,
  output logic [DIM_W-1:0]             sts_width,
  output logic [DIM_W-1:0]             sts_height
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = AXIS_USER_WIDTH + 1 + KEEP_W + AXIS_DATA_WIDTH;

  capture_state_t         state_q, state_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d, num_frames_q, num_frames_d, frames_inc;
  logic [DIM_W-1:0]       height_q, height_d, line_q, line_d, line_inc;
  logic                   err_q, err_d, stop_q, stop_d, done_q, done_d, tready_q, tready_d;
  logic                   accept, sof, eol, last_frame, stop_now;
  logic                   push, frame_done, run_end;
  logic                   buf_full_next, buf_empty_next;
  logic [BEAT_W-1:0]      m_beat;

  assign accept     = s_axis_tvalid & tready_q;
  assign sof        = s_axis_tuser[SOF_BIT];
  assign eol        = s_axis_tlast;
  assign line_inc   = line_q + 1'b1;
  assign frames_inc = (frames_q == '1) ? frames_q : frames_q + 1'b1;
  assign last_frame = (num_frames_q != '0) && (frames_inc == num_frames_q);
  assign stop_now   = stop_q | cfg_stop;

  // A SOF in CAPTURE is only forwarded when the truncated frame does not end the run.
  assign push = accept &&
                ((state_q == ST_ARMED && !cfg_stop && sof) ||
                 (state_q == ST_CAPTURE && !(sof && (last_frame || stop_now))));

  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    num_frames_d = num_frames_q;
    height_d     = height_q;
    line_d       = line_q;
    err_d        = err_q;
    stop_d       = stop_q;
    done_d       = 1'b0;
    frame_done   = 1'b0;
    run_end      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d      = ST_ARMED;
          frames_d     = '0;
          err_d        = 1'b0;
          stop_d       = 1'b0;
          num_frames_d = cfg_num_frames;
          height_d     = cfg_height;
        end
      end
      ST_ARMED: begin
        if (cfg_stop) begin
          run_end = 1'b1;
        end else if (accept && sof) begin
          line_d  = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (cfg_stop) stop_d = 1'b1;
        if (accept && sof) begin
          frame_done = 1'b1;
          err_d      = 1'b1;
          line_d     = '0;
          if (last_frame || stop_now) begin
            run_end = 1'b1;
            done_d  = 1'b1;
          end
        end else if (accept && eol) begin
          line_d = line_inc;
          if (line_inc == height_q) begin
            frame_done = 1'b1;
            if (last_frame || stop_now) begin
              run_end = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (buf_empty_next) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_done) frames_d = frames_inc;
    if (run_end)    state_d  = buf_empty_next ? ST_IDLE : ST_DRAIN;
    // ARMED also holds off while the tail of the previous frame fills the buffer, so a SOF is never lost.
    case (state_d)
      ST_IDLE:              tready_d = 1'b1;
      ST_ARMED, ST_CAPTURE: tready_d = ~buf_full_next;
      default:              tready_d = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      frames_q     <= '0;
      num_frames_q <= '0;
      height_q     <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frames_q     <= frames_d;
      num_frames_q <= num_frames_d;
      height_q     <= height_d;
      line_q       <= line_d;
      err_q        <= err_d;
      stop_q       <= stop_d;
      done_q       <= done_d;
      tready_q     <= tready_d;
    end
  end

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk         (aclk),
    .rst_n       (aresetn),
    .push_i      (push),
    .data_i      ({s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .full_next_o (buf_full_next),
    .empty_next_o(buf_empty_next),
    .m_valid_o   (m_axis_tvalid),
    .m_data_o    (m_beat),
    .m_ready_i   (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_beat;
  assign s_axis_tready = tready_q;
  assign sts_busy      = (state_q != ST_IDLE);
  assign sts_done      = done_q;
  assign sts_frames    = frames_q;
  assign sts_err_short = err_q;

`ifdef CAMLINK_CAPTURE_STATS_EN
  logic [DIM_W-1:0] pix_q, pix_d, width_q, width_d, sheight_q, sheight_d, beat_num;

  always_comb begin
    pix_d     = pix_q;
    width_d   = width_q;
    sheight_d = sheight_q;
    beat_num  = (state_q == ST_ARMED || sof) ? DIM_W'(1) : pix_q + 1'b1;
    if (push) begin
      if (eol) begin
        width_d = beat_num;
        pix_d   = '0;
      end else begin
        pix_d = beat_num;
      end
    end
    // A short frame ends on its successor's SOF, so only the lines already closed count.
    if (frame_done) sheight_d = sof ? line_q : line_inc;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_q     <= '0;
      width_q   <= '0;
      sheight_q <= '0;
    end else begin
      pix_q     <= pix_d;
      width_q   <= width_d;
      sheight_q <= sheight_d;
    end
  end

  assign sts_width  = width_q;
  assign sts_height = sheight_q;
`else
  assign sts_width  = '0;
  assign sts_height = '0;
`endif

endmodule

// File: tb/tb_cameralink_capture_ctrl.sv
// Self-checking bench for cameralink_capture_ctrl: table-driven frame runs plus
// hand sequences for short frames, stops and reset, with a beat scoreboard.
module tb_cameralink_capture_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [0:0]  user;
  } beat_t;

  typedef struct {
    int nf;
    int h;
    int w;
    int bp;
    int exp_frames;
    int exp_done;
  } run_vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [15:0] cfg_num_frames = '0;
  logic [15:0] cfg_height = '0;
  logic        sts_busy, sts_done, sts_err_short;
  logic [15:0] sts_frames, sts_width, sts_height;

  int    n_checks = 0;
  int    n_fail = 0;
  int    done_cnt = 0;
  int    rmode = 0;
  int    cyc = 0;
  beat_t sb[$];
  beat_t hold_b;
  bit    hold_v = 0;

  cameralink_capture_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_num_frames(cfg_num_frames),
    .cfg_height(cfg_height), .sts_busy(sts_busy), .sts_done(sts_done),
    .sts_frames(sts_frames), .sts_err_short(sts_err_short),
    .sts_width(sts_width), .sts_height(sts_height)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always on, 500 ns on / 100 ns off, or held low.
  always @(posedge aclk) begin
    #2;
    cyc++;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 60) < 50;
      default: m_tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop, hold-stable check, done pulse counter.
  always @(negedge aclk) begin
    beat_t now_b;
    beat_t exp_b;
    now_b = {m_tdata, m_tkeep, m_tlast, m_tuser};
    if (!aresetn) begin
      hold_v = 0;
    end else begin
      if (hold_v) check("hold_stable", {m_tvalid, now_b}, {1'b1, hold_b});
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {1'b0, now_b}, {1'b1, now_b});
        end else begin
          exp_b = sb.pop_front();
          check("beat", now_b, exp_b);
        end
      end
      hold_v = m_tvalid && !m_tready;
      hold_b = now_b;
      if (sts_done) done_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic u, input bit exp);
    int    t;
    beat_t b;
    t = 0;
    b.data = d;
    b.keep = d[3:0] | 4'h1;
    b.last = l;
    b.user = u;
    s_tdata = b.data; s_tkeep = b.keep; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    while (!s_tready && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (!s_tready) check("src_timeout", 1'b0, 1'b1);
    else if (exp) sb.push_back(b);
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_px(input int scn, input int frm, input int ln, input int p0, input int p1,
                         input int w, input bit sof, input bit exp);
    for (int p = p0; p < p1; p++)
      send_beat({8'(scn), 8'(frm), 8'(ln), 8'(p)}, p == w - 1, sof && (p == 0), exp);
  endtask

  task automatic send_frame(input int scn, input int frm, input int h, input int w, input bit exp);
    for (int l = 0; l < h; l++) send_px(scn, frm, l, 0, w, w, l == 0, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse(input bit start, input bit stop, input int nf, input int h);
    cfg_num_frames = 16'(nf);
    cfg_height = 16'(h);
    cfg_start = start;
    cfg_stop = stop;
    @(negedge aclk);
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((sts_busy || sb.size() != 0 || m_tvalid) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    check(name, t < 3000, 1'b1);
  endtask

  run_vec_t vecs[4];

  initial begin
    int d0;
    int ew;
    int eh;

    vecs[0] = '{nf: 2, h: 3, w: 20, bp: 0, exp_frames: 2, exp_done: 1};
    vecs[1] = '{nf: 2, h: 3, w: 20, bp: 1, exp_frames: 2, exp_done: 1};
    vecs[2] = '{nf: 1, h: 1, w: 5,  bp: 0, exp_frames: 1, exp_done: 1};
    vecs[3] = '{nf: 3, h: 2, w: 7,  bp: 1, exp_frames: 3, exp_done: 1};

    // Reset state
    #12;
    check("reset_outs", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, s_tready,
                         sts_busy, sts_done, sts_err_short, sts_frames}, 64'h0);
    check("reset_dims", {sts_width, sts_height}, 64'h0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 check("tready_before_edge", s_tready, 1'b0);
    @(negedge aclk);
    check("tready_after_edge", s_tready, 1'b1);

    // Table-driven frame runs
    foreach (vecs[i]) begin
      rmode = vecs[i].bp;
      send_px(i, 99, 0, 0, vecs[i].w, vecs[i].w, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, vecs[i].nf, vecs[i].h);
      check("run_busy", sts_busy, 1'b1);
      d0 = done_cnt;
      for (int l = 1; l < 3; l++) send_px(i, 98, l, 0, vecs[i].w, vecs[i].w, 1'b0, 1'b0);
      for (int f = 0; f <= vecs[i].nf; f++) send_frame(i, f, vecs[i].h, vecs[i].w, f < vecs[i].nf);
      wait_idle("run_idle");
      rmode = 0;
      check("run_frames", sts_frames, 64'(vecs[i].exp_frames));
      check("run_done", done_cnt - d0, 64'(vecs[i].exp_done));
      check("run_err", sts_err_short, 1'b0);
      check("run_tready_idle", s_tready, 1'b1);
`ifdef CAMLINK_CAPTURE_STATS_EN
      ew = vecs[i].w;
      eh = vecs[i].h;
`else
      ew = 0;
      eh = 0;
`endif
      check("run_stats", {sts_width, sts_height}, {16'(ew), 16'(eh)});
      idle(3);
    end

    // Short frame: SOF after 2 of 4 lines
    pulse(1'b1, 1'b0, 2, 4);
    d0 = done_cnt;
    send_frame(10, 0, 2, 6, 1'b1);
    send_frame(10, 1, 4, 6, 1'b1);
    send_frame(10, 2, 4, 6, 1'b0);
    wait_idle("short_idle");
    check("short_err", sts_err_short, 1'b1);
    check("short_frames", sts_frames, 64'd2);
    check("short_done", done_cnt - d0, 64'd1);
    idle(3);

    // Graceful stop during line 2 of 3, continuous mode
    pulse(1'b1, 1'b0, 0, 3);
    check("start_clears_err", sts_err_short, 1'b0);
    d0 = done_cnt;
    send_frame(11, 0, 3, 8, 1'b1);
    send_px(11, 1, 0, 0, 8, 8, 1'b1, 1'b1);
    send_px(11, 1, 1, 0, 4, 8, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 0, 3);
    check("stop_pending_busy", sts_busy, 1'b1);
    send_px(11, 1, 1, 4, 8, 8, 1'b0, 1'b1);
    send_px(11, 1, 2, 0, 8, 8, 1'b0, 1'b1);
    send_frame(11, 2, 3, 8, 1'b0);
    wait_idle("stop_idle");
    check("stop_frames", sts_frames, 64'd2);
    check("stop_done", done_cnt - d0, 64'd1);
    idle(3);

    // Start+stop together in IDLE, then stop while armed
    d0 = done_cnt;
    pulse(1'b1, 1'b1, 0, 2);
    check("start_wins", sts_busy, 1'b1);
    send_px(12, 0, 0, 0, 5, 5, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 0, 2);
    check("armed_stop_idle", sts_busy, 1'b0);
    send_frame(12, 1, 2, 5, 1'b0);
    idle(3);
    check("armed_stop_no_done", done_cnt - d0, 64'd0);
    check("armed_stop_frames", sts_frames, 64'd0);
    check("armed_stop_no_output", sb.size() + m_tvalid, 64'd0);

    // Reset mid-frame with data held in the buffer
    rmode = 2;
    idle(2);
    pulse(1'b1, 1'b0, 0, 3);
    d0 = done_cnt;
    send_px(13, 0, 0, 0, 2, 8, 1'b1, 1'b0);
    idle(1);
    check("rst_mid_buf_full", {m_tvalid, s_tready}, 2'b10);
    #2 aresetn = 1'b0;
    #1 check("rst_mid_outs", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, s_tready,
                              sts_busy, sts_done, sts_err_short, sts_frames}, 64'h0);
    check("rst_mid_dims", {sts_width, sts_height}, 64'h0);
    idle(3);
    aresetn = 1'b1;
    rmode = 0;
    #1 check("rst_mid_tready_low", s_tready, 1'b0);
    @(negedge aclk);
    check("rst_mid_tready_high", {s_tready, sts_busy, m_tvalid}, 3'b100);
    idle(4);
    check("rst_mid_no_done", done_cnt - d0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout, expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
